// File: rtl/bitstream_loader.sv
// bitstream_loader: accepts host words over valid/ready and shifts them LSB-first onto
// the Core configuration chain, holding the fabric in reset until LEN_BITS bits are in.
//   state  | meaning
//   S_IDLE | out of reset, waiting for start
//   S_LOAD | accepting words and shifting bits onto prog_in/prog_en
//   S_DONE | chain fully loaded, fabric released from reset
//   S_ERR  | aborted or host stalled too long; fabric held in reset
module bitstream_loader #(
  parameter int LEN_BITS  = 4416,
  parameter int WORD_W    = 32,
  parameter int STALL_MAX = 255
) (
  input  logic              prog_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              prog_in,
  output logic              prog_en,
  output logic              fabric_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [12:0]       bit_count
);

  localparam int CNT_W   = 13;
  localparam int REM_W   = $clog2(WORD_W + 1);
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               pin_q, pin_d;
  logic               pen_q, pen_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               frst_q, frst_d;

  logic               in_load;
  logic               has_bit;
  logic               ready;
  logic               xfer;
  logic [CNT_W-1:0]   left;
  logic [REM_W-1:0]   chunk;

  assign in_load = (state_q == S_LOAD);
  assign has_bit = (rem_q != '0);
  assign left    = CNT_W'(LEN_BITS) - acc_q;
  // Final word may be partial; only its low `left` bits are kept.
  assign chunk   = (left >= CNT_W'(WORD_W)) ? REM_W'(WORD_W) : REM_W'(left);
  // Ready while the last buffered bit leaves, so a held-valid host streams without gaps.
  assign ready   = in_load && !abort && (rem_q <= REM_W'(1)) && (acc_q < CNT_W'(LEN_BITS));
  assign xfer    = ready && wr_valid;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    pin_d   = pin_q;
    pen_d   = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    frst_d  = frst_q;

    case (state_q)
      S_LOAD: begin
        if (abort) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          frst_d  = 1'b0;
        end else begin
          if (has_bit) begin
            pin_d = buf_q[0];
            pen_d = 1'b1;
            buf_d = buf_q >> 1;
            rem_d = rem_q - 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LEN_BITS - 1)) state_d = S_DONE;
          end
          if (xfer) begin
            buf_d   = wr_data;
            rem_d   = chunk;
            acc_d   = acc_q + CNT_W'(chunk);
            stall_d = '0;
          end else if (!has_bit) begin
            stall_d = stall_q + 1'b1;
            if (stall_q == STALL_W'(STALL_MAX - 1)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
      end
      S_IDLE, S_DONE, S_ERR: begin
        // done/fabric release lag the last driven bit by one cycle.
        if (state_q == S_DONE) begin
          done_d = 1'b1;
          frst_d = 1'b1;
        end
        if (start) begin
          state_d = S_LOAD;
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          stall_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          frst_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      pin_q   <= 1'b0;
      pen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      frst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      pin_q   <= pin_d;
      pen_q   <= pen_d;
      done_q  <= done_d;
      err_q   <= err_d;
      frst_q  <= frst_d;
    end
  end

  assign wr_ready     = ready;
  assign prog_in      = pin_q;
  assign prog_en      = pen_q;
  assign fabric_rst_n = frst_q;
  assign busy         = in_load;
  assign done         = done_q;
  assign error        = err_q;
  assign bit_count    = cnt_q;

endmodule

// File: doc/bitstream_loader.md
Name: bitstream_loader

Overview:
- Configuration controller that sequences programming of the fabric Core.
- Accepts the bitstream as 32-bit words from a host over a valid/ready handshake.
- Serialises the words LSB-first onto the Core's prog_in/prog_en shift chain and counts exactly LEN_BITS bits.
- Holds the fabric in reset until the load completes, then releases it; reports completion, stalls and errors.

Parameters:
LEN_BITS, 4416, total configuration chain length in bits (69 bits x 64 tiles).
WORD_W, 32, host word width.
STALL_MAX, 255, max consecutive cycles waiting for a word mid-load before flagging an error.

Ports:
prog_clk  in  1  loader clock; same clock as the Core shift chain.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR.
abort  in  1  level; forces the ERR state from LOAD.
wr_data  in  WORD_W  bitstream word; bit 0 is shifted first.
wr_valid  in  1  word present.
wr_ready  out  1  loader accepts the word this cycle (transfer occurs when valid & ready).
prog_in  out  1  serial config bit to the Core.
prog_en  out  1  shift enable to the Core.
fabric_rst_n  out  1  low while unconfigured or loading; high only in DONE.
busy  out  1  high in LOAD.
done  out  1  high in DONE.
error  out  1  high in ERR.
bit_count  out  13  number of bits shifted in the current or last load.

Behaviour:
- Reset (async, rst_n=0) sets: state IDLE, prog_in=0, prog_en=0, wr_ready=0, fabric_rst_n=0, busy=0, done=0, error=0, bit_count=0, word buffer empty, stall counter 0.
- States: IDLE, LOAD, DONE, ERR.
- IDLE/DONE/ERR --start--> LOAD. On entry: bit_count=0, buffer empty, done=0, error=0, fabric_rst_n=0.
- LOAD, word buffer:
  - 32-bit shift buffer plus 6-bit remaining-bits count.
  - wr_ready=1 only when the buffer is empty, or will be empty this cycle (last buffered bit shifting out), and words are still needed: bits accepted < LEN_BITS.
  - A new word is accepted on the same edge the last bit of the previous word shifts, giving a gap-free stream when wr_valid is held high.
- LOAD, shifting:
  - On each edge where the buffer holds a bit: prog_in <= buffer[0], prog_en <= 1, buffer shifts right, bit_count increments.
  - When the buffer is empty: prog_en <= 0 and prog_in holds its value (stall).
  - prog_in and prog_en are registered, so the Core captures bit k on the edge after it is driven.
- Latency: the first bit appears on prog_in/prog_en one cycle after the first accepted word.
- Partial final word: when LEN_BITS is not a multiple of WORD_W, only the low (LEN_BITS mod WORD_W) bits of the final word are shifted; the rest are discarded. wr_ready stays 0 after the final word is accepted.
- Completion: on the edge the LEN_BITS-th bit is driven, the FSM moves to DONE. On the next cycle prog_en=0, done=1 and fabric_rst_n=1.
  - Exactly LEN_BITS cycles with prog_en=1 occur per load, never more.
- Stall counter:
  - Increments on each LOAD cycle with an empty buffer and no transfer.
  - Clears on any transfer.
  - Reaching STALL_MAX moves the FSM to ERR.
- abort in LOAD moves the FSM to ERR on the next edge. abort has priority over a simultaneous transfer; that word is not consumed.
- ERR state: error=1, prog_en=0, wr_ready=0, fabric_rst_n=0, bit_count frozen at the abort point.
- start in LOAD: ignored. start and abort in the same cycle in LOAD: abort wins.
- Extra wr_valid in IDLE/DONE/ERR: wr_ready=0, no transfer.
- bit_count never exceeds LEN_BITS.
- rst_n asserted mid-load: immediate return to reset values; the Core chain content is undefined.

Test Plan:
- Full load, wr_valid held high, words 0xAAAAAAAA x138: prog_en high for exactly 4416 consecutive cycles, prog_in alternates 0,1,0,1…; done=1 and fabric_rst_n=1 one cycle after the last bit; bit_count=4416; wr_ready is high for 138 transfers total.
- Gapped host, valid dropped 10 cycles after each word: prog_en low during gaps with prog_in held; the total of 4416 enable cycles is unchanged; no error.
- LEN_BITS=69 override, words 0x0001FFFF then 0xFFFFFFFF then 0x0000001F: exactly 69 enable cycles; prog_in sequence is 17 ones, 15 zeros, 32 ones, 5 ones; word bits 5..31 of the third word are never shifted.
- Stall timeout, STALL_MAX=255: supply 3 words, then hold wr_valid=0: error=1 after 255 idle cycles; bit_count=96; fabric_rst_n=0.
- abort asserted at bit_count=1000 while wr_valid=1: ERR on the next edge, word not consumed, prog_en=0; a new start restarts with bit_count=0 and completes normally.
- Async reset pulse at bit_count=2000: all outputs return to reset values immediately without a clock; a subsequent start and full load reaches done.
